hamming_encoder_74_tx: RTL and testbench

// - Hamming(7,4) encoder with output buffering. Converts 4-bit data nibbles into 7-bit

---
 rtl/hamming_encoder_74_tx.sv | 58 +++++
 tb/tb_hamming_encoder_74_tx.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/hamming_encoder_74_tx.sv
// hamming_encoder_74_tx: Hamming(7,4) encoder feeding a DEPTH-entry codeword FIFO; HAMMING_ERR_INJECT_EN adds inj_req/inj_pos bit-flip injection
module hamming_encoder_74_tx #(
  parameter int DEPTH = 4,
  parameter int LEVEL_W = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ena,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3:0]         data_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [6:0]         code_out,
  output logic [LEVEL_W-1:0] fifo_level,
  output logic [7:0]         debug_count_out
`ifdef HAMMING_ERR_INJECT_EN
  ,
  input  logic               inj_req,
  input  logic [2:0]         inj_pos
`endif
);
  localparam int PW = $clog2(DEPTH);
  logic [6:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [6:0] code, stored;
  logic push, pop;
  always_comb begin
    code = {data_in[3], data_in[2], data_in[1],
            data_in[1] ^ data_in[2] ^ data_in[3],
            data_in[0],
            data_in[0] ^ data_in[2] ^ data_in[3],
            data_in[0] ^ data_in[1] ^ data_in[3]};
`ifdef HAMMING_ERR_INJECT_EN
    stored = code ^ ((inj_req && inj_pos != 3'd7) ? 7'd1 << inj_pos : 7'd0);
`else
    stored = code;
`endif
    in_ready = ena && !rst && (fifo_level != LEVEL_W'(DEPTH));
    out_valid = fifo_level != '0;
    code_out = out_valid ? mem[rd_ptr] : 7'h00;
    push = in_valid && in_ready;
    pop = out_valid && out_ready;
  end
  always_ff @(posedge clk) if (push) mem[wr_ptr] <= stored;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fifo_level <= '0;
      debug_count_out <= '0;
    end else begin
      wr_ptr <= wr_ptr + PW'(push);
      rd_ptr <= rd_ptr + PW'(pop);
      fifo_level <= fifo_level + LEVEL_W'(push) - LEVEL_W'(pop);
      debug_count_out <= debug_count_out + 8'(push);
    end
endmodule

// File: tb/tb_hamming_encoder_74_tx.sv
// tb_hamming_encoder_74_tx: scoreboard bench for hamming_encoder_74_tx
module tb_hamming_encoder_74_tx;
  localparam int DEPTH = 4;
  logic clk = 0, rst = 1, ena = 1, in_valid = 0, out_ready = 0;
  logic in_ready, out_valid;
  logic [3:0] data_in = '0;
  logic [6:0] code_out;
  logic [2:0] fifo_level;
  logic [7:0] debug_count_out;
  logic inj_req = 0;
  logic [2:0] inj_pos = 3'd7;
  int n_cmp = 0, n_err = 0;
  logic [7:0] exp_cnt = '0;
  typedef struct {logic [6:0] code; logic [3:0] nib; logic [2:0] syn;} ent_t;
  ent_t q[$];
  ent_t ent, got;
  logic [6:0] fix;
  logic [2:0] syn;
  always #5 clk = ~clk;
  hamming_encoder_74_tx #(.DEPTH(DEPTH), .LEVEL_W(3)) dut (
    .clk(clk), .rst(rst), .ena(ena), .in_valid(in_valid), .in_ready(in_ready),
    .data_in(data_in), .out_valid(out_valid), .out_ready(out_ready), .code_out(code_out),
    .fifo_level(fifo_level), .debug_count_out(debug_count_out)
`ifdef HAMMING_ERR_INJECT_EN
    , .inj_req(inj_req), .inj_pos(inj_pos)
`endif
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic logic [6:0] enc(input logic [3:0] d);
    logic p1, p2, p4;
    p1 = d[0] ^ d[1] ^ d[3];
    p2 = d[0] ^ d[2] ^ d[3];
    p4 = d[1] ^ d[2] ^ d[3];
    return {d[3], d[2], d[1], p4, d[0], p2, p1};
  endfunction
  always @(negedge clk) if (!rst) begin
    if (in_valid && in_ready) begin
      ent.code = enc(data_in);
      ent.nib = data_in;
      ent.syn = 3'd0;
      if (inj_req && inj_pos != 3'd7) begin
        ent.code[inj_pos] = ~ent.code[inj_pos];
        ent.syn = inj_pos + 3'd1;
      end
      q.push_back(ent);
      exp_cnt++;
    end
    if (out_valid && out_ready) begin
      if (q.size() == 0) chk("pop_empty", 32'(q.size()), 1);
      else begin
        got = q.pop_front();
        chk("code", {25'd0, code_out}, {25'd0, got.code});
        syn = {code_out[3] ^ code_out[4] ^ code_out[5] ^ code_out[6],
               code_out[1] ^ code_out[2] ^ code_out[5] ^ code_out[6],
               code_out[0] ^ code_out[2] ^ code_out[4] ^ code_out[6]};
        fix = code_out;
        if (syn != 0) fix[syn - 3'd1] = ~fix[syn - 3'd1];
        chk("syndrome", {29'd0, syn}, {29'd0, got.syn});
        chk("decoded", {28'd0, fix[6], fix[5], fix[4], fix[2]}, {28'd0, got.nib});
      end
    end
  end
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic drain();
    int n = 0;
    out_ready = 1;
    while (fifo_level != 0 && n < 50) begin
      cyc();
      n++;
    end
    chk("drain", {29'd0, fifo_level}, 0);
  endtask
  task automatic push_one(input logic [3:0] d, input logic [6:0] exp);
    data_in = d;
    in_valid = 1;
    cyc();
    in_valid = 0;
    chk("latency", {25'd0, code_out}, {25'd0, exp});
    cyc();
  endtask
  initial begin
    cyc();
    chk("rst_in_ready", {31'd0, in_ready}, 0);
    chk("rst_out_valid", {31'd0, out_valid}, 0);
    chk("rst_code", {25'd0, code_out}, 0);
    chk("rst_level", {29'd0, fifo_level}, 0);
    chk("rst_dbg", {24'd0, debug_count_out}, 0);
    rst = 0;
    cyc();
    chk("post_rst_valid", {31'd0, out_valid}, 0);
    chk("post_rst_ready", {31'd0, in_ready}, 1);
    out_ready = 1;
    push_one(4'h0, 7'h00);
    push_one(4'hB, 7'h55);
    push_one(4'h1, 7'h07);
    push_one(4'hF, 7'h7F);
    in_valid = 1;
    for (int i = 0; i < 16; i++) begin
      data_in = 4'(i);
      cyc();
    end
    in_valid = 0;
    drain();
    chk("dbg_20", {24'd0, debug_count_out}, {24'd0, exp_cnt});
    out_ready = 0;
    in_valid = 1;
    for (int i = 0; i < DEPTH; i++) begin
      data_in = 4'(i + 3);
      cyc();
    end
    chk("full_level", {29'd0, fifo_level}, DEPTH);
    chk("full_ready", {31'd0, in_ready}, 0);
    data_in = 4'h9;
    cyc();
    cyc();
    chk("full_hold", {29'd0, fifo_level}, DEPTH);
    out_ready = 1;
    chk("full_pop_ready", {31'd0, in_ready}, 0);
    cyc();
    chk("full_pop_level", {29'd0, fifo_level}, DEPTH - 1);
    in_valid = 0;
    drain();
    ena = 0;
    in_valid = 1;
    #1;
    chk("ena_ready", {31'd0, in_ready}, 0);
    cyc();
    chk("ena_level", {29'd0, fifo_level}, 0);
    ena = 1;
    out_ready = 0;
    data_in = 4'h6;
    cyc();
    data_in = 4'hC;
    cyc();
    chk("two_level", {29'd0, fifo_level}, 2);
    data_in = 4'hA;
    out_ready = 1;
    cyc();
    chk("simul_level", {29'd0, fifo_level}, 2);
    in_valid = 0;
    drain();
    out_ready = 0;
    in_valid = 1;
    for (int i = 0; i < 3; i++) begin
      data_in = 4'(i + 7);
      cyc();
    end
    in_valid = 0;
    chk("pre_rst_level", {29'd0, fifo_level}, 3);
    chk("pre_rst_dbg", {24'd0, debug_count_out}, {24'd0, exp_cnt});
    rst = 1;
    #1;
    chk("mid_rst_valid", {31'd0, out_valid}, 0);
    chk("mid_rst_level", {29'd0, fifo_level}, 0);
    chk("mid_rst_dbg", {24'd0, debug_count_out}, 0);
    q.delete();
    exp_cnt = '0;
    cyc();
    cyc();
    rst = 0;
    out_ready = 1;
    for (int i = 0; i < 4; i++) cyc();
    chk("after_rst_valid", {31'd0, out_valid}, 0);
    chk("after_rst_level", {29'd0, fifo_level}, 0);
`ifdef HAMMING_ERR_INJECT_EN
    inj_req = 1;
    inj_pos = 3'd4;
    data_in = 4'hB;
    in_valid = 1;
    cyc();
    in_valid = 0;
    inj_req = 0;
    inj_pos = 3'd7;
    chk("inject", {25'd0, code_out}, 32'h45);
    drain();
`endif
    chk("sb_left", 32'(q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
